// File: rtl/alu_operand_collector.sv
// Collects ALU operands that may arrive on different cycles and issues a one-cycle ce strobe.
// Issue latency is one cycle once all needed operands are present; a partial command times out after TIMEOUT wait cycles.
module alu_operand_collector #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   in_valid,
  input  logic [N-1:0] in_opa,
  input  logic [N-1:0] in_opb,
  input  logic [3:0]   in_cmd,
  input  logic         in_mode,
  input  logic         in_cin,
  input  logic         in_ce,
  output logic [N-1:0] opa,
  output logic [N-1:0] opb,
  output logic [3:0]   cmd,
  output logic         mode,
  output logic         cin,
  output logic         ce,
  output logic [1:0]   inp_valid,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  localparam logic [4:0] LP_TMO = 5'(TIMEOUT);

  state_t         r_state, w_next;
  logic [4:0]     r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_pa, r_pb;
  logic [3:0]     r_pcmd;
  logic           r_pmode, r_pcin;
  logic           w_a_only, w_b_only, w_need_a, w_need_b;
  logic           w_issue, w_cap, w_tmo;
  logic [1:0]     w_issue_vld;

  assign w_a_only = in_mode ? (in_cmd == 4'd4 || in_cmd == 4'd5)
                            : (in_cmd == 4'd6 || in_cmd == 4'd8 || in_cmd == 4'd9);
  assign w_b_only = in_mode ? (in_cmd == 4'd6 || in_cmd == 4'd7)
                            : (in_cmd == 4'd7 || in_cmd == 4'd10 || in_cmd == 4'd11);
  assign w_need_a = !w_b_only;
  assign w_need_b = !w_a_only;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_issue_vld = 2'b00;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_ce && in_valid != 2'b00) begin
          if ((!w_need_a || in_valid[0]) && (!w_need_b || in_valid[1])) begin
            w_issue     = 1'b1;
            w_issue_vld = in_valid;
          end else if (w_need_a && w_need_b) begin
            // Exactly one of the two required operands is present: park it.
            w_cap     = 1'b1;
            w_cnt_nxt = 5'd0;
            w_next    = in_valid[0] ? WAIT_B : WAIT_A;
          end
        end
      end
      WAIT_A, WAIT_B: begin
        if ((r_state == WAIT_A) ? in_valid[0] : in_valid[1]) begin
          w_issue     = 1'b1;
          w_issue_vld = 2'b11;
          w_next      = IDLE;
        end else if (r_cnt + 5'd1 == LP_TMO) begin
          w_tmo     = 1'b1;
          w_cnt_nxt = 5'd0;
          w_next    = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Parked fields live apart from the outputs so outputs only change on issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pa    <= '0;
      r_pb    <= '0;
      r_pcmd  <= 4'd0;
      r_pmode <= 1'b0;
      r_pcin  <= 1'b0;
    end else if (w_cap) begin
      r_pa    <= in_opa;
      r_pb    <= in_opb;
      r_pcmd  <= in_cmd;
      r_pmode <= in_mode;
      r_pcin  <= in_cin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa         <= '0;
      opb         <= '0;
      cmd         <= 4'd0;
      mode        <= 1'b0;
      cin         <= 1'b0;
      ce          <= 1'b0;
      inp_valid   <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      ce          <= w_issue;
      inp_valid   <= w_issue_vld;
      timeout_err <= w_tmo;
      if (w_issue) begin
        opa  <= (r_state == WAIT_B) ? r_pa : in_opa;
        opb  <= (r_state == WAIT_A) ? r_pb : in_opb;
        cmd  <= (r_state == IDLE) ? in_cmd  : r_pcmd;
        mode <= (r_state == IDLE) ? in_mode : r_pmode;
        cin  <= (r_state == IDLE) ? in_cin  : r_pcin;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Randomised and directed bench for alu_operand_collector against a transaction-level model.
module tb_alu_operand_collector;
  localparam int N   = 8;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   in_valid = 2'b00;
  logic [N-1:0] in_opa = '0, in_opb = '0;
  logic [3:0]   in_cmd = 4'd0;
  logic         in_mode = 1'b0, in_cin = 1'b0, in_ce = 1'b0;
  logic [N-1:0] opa, opb;
  logic [3:0]   cmd;
  logic         mode, cin, ce, busy, timeout_err;
  logic [1:0]   inp_valid;

  alu_operand_collector #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opa(in_opa), .in_opb(in_opb),
    .in_cmd(in_cmd), .in_mode(in_mode), .in_cin(in_cin), .in_ce(in_ce),
    .opa(opa), .opb(opb), .cmd(cmd), .mode(mode), .cin(cin), .ce(ce),
    .inp_valid(inp_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model: pending command (0 none, 1 missing A, 2 missing B) and expected outputs
  int           m_pend, m_wait;
  logic [N-1:0] m_pa, m_pb;
  logic [3:0]   m_cmd;
  logic         m_mode, m_cin;
  logic [N-1:0] e_opa, e_opb;
  logic [3:0]   e_cmd;
  logic         e_mode, e_cin, e_ce, e_busy, e_tmo;
  logic [1:0]   e_iv;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] need(input logic md, input logic [3:0] c);
    logic [1:0] r;
    r = 2'b11;
    if (md) begin
      case (c)
        4'd4, 4'd5: r = 2'b01;
        4'd6, 4'd7: r = 2'b10;
        default:    r = 2'b11;
      endcase
    end else begin
      case (c)
        4'd6, 4'd8, 4'd9:   r = 2'b01;
        4'd7, 4'd10, 4'd11: r = 2'b10;
        default:            r = 2'b11;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_wait = 0; m_pa = '0; m_pb = '0; m_cmd = 0; m_mode = 0; m_cin = 0;
    e_opa = '0; e_opb = '0; e_cmd = 0; e_mode = 0; e_cin = 0;
    e_ce = 0; e_busy = 0; e_tmo = 0; e_iv = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] nd;
    e_ce = 0; e_iv = 2'b00; e_tmo = 0;
    if (m_pend == 0) begin
      if (in_ce && in_valid != 2'b00) begin
        nd = need(in_mode, in_cmd);
        if ((in_valid & nd) == nd) begin
          e_ce = 1; e_iv = in_valid;
          e_opa = in_opa; e_opb = in_opb; e_cmd = in_cmd; e_mode = in_mode; e_cin = in_cin;
        end else if (nd == 2'b11) begin
          m_pend = in_valid[0] ? 2 : 1; m_wait = 0;
          m_pa = in_opa; m_pb = in_opb; m_cmd = in_cmd; m_mode = in_mode; m_cin = in_cin;
        end
      end
    end else if ((m_pend == 2) ? in_valid[1] : in_valid[0]) begin
      e_ce = 1; e_iv = 2'b11;
      e_opa = (m_pend == 2) ? m_pa : in_opa;
      e_opb = (m_pend == 2) ? in_opb : m_pb;
      e_cmd = m_cmd; e_mode = m_mode; e_cin = m_cin;
      m_pend = 0;
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        e_tmo = 1; m_pend = 0;
      end
    end
    e_busy = (m_pend != 0);
  endtask

  // Drive one cycle of inputs, advance through the edge, land at posedge+1.
  task automatic cyc(input logic [1:0] v, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [3:0] c, input logic md, input logic ci, input logic e);
    in_valid = v; in_opa = a; in_opb = b; in_cmd = c; in_mode = md; in_cin = ci; in_ce = e;
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ce", ce, e_ce);
      cmp("inp_valid", inp_valid, e_iv);
      cmp("timeout_err", timeout_err, e_tmo);
      cmp("busy", busy, e_busy);
      cmp("opa", opa, e_opa);
      cmp("opb", opb, e_opb);
      cmp("cmd", cmd, e_cmd);
      cmp("mode", mode, e_mode);
      cmp("cin", cin, e_cin);
      cmp("ce_and_tmo", int'(ce && timeout_err), 0);
    end
  end

  initial begin
    int busy_cnt;
    bit quiet;
    int r;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1;
    cmp("rst_ce", ce, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_opa", opa, 0);
    cmp("rst_iv", inp_valid, 0);
    rst = 1'b1;

    // both operands at once, issued on the very first edge after release
    cyc(2'b11, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b1);
    cmp("d1_ce", ce, 1); cmp("d1_iv", inp_valid, 3);
    cmp("d1_opa", opa, 8'h0F); cmp("d1_opb", opb, 8'h01);
    cmp("d1_cmd", cmd, 0); cmp("d1_busy", busy, 0);

    // opa first, opb three idle cycles later
    busy_cnt = 0;
    cyc(2'b01, 8'h03, 8'hEE, 4'd9, 1'b1, 1'b0, 1'b1);
    if (busy) busy_cnt++;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (busy) busy_cnt++;
    end
    cyc(2'b10, 8'h55, 8'h04, 4'd0, 1'b0, 1'b0, 1'b0);
    cmp("d2_busy_cycles", busy_cnt, 4);
    cmp("d2_ce", ce, 1); cmp("d2_iv", inp_valid, 3);
    cmp("d2_opa", opa, 8'h03); cmp("d2_opb", opb, 8'h04); cmp("d2_cmd", cmd, 9);

    // opb only, opa never arrives
    cyc(2'b10, 8'h00, 8'hAA, 4'd4, 1'b0, 1'b0, 1'b1);
    idle(15);
    cmp("d3_busy15", busy, 1); cmp("d3_tmo15", timeout_err, 0);
    idle(1);
    cmp("d3_tmo", timeout_err, 1); cmp("d3_ce", ce, 0); cmp("d3_busy", busy, 0);
    cmp("d3_opb_held", opb, 8'h04);
    idle(1);
    cmp("d3_tmo_pulse", timeout_err, 0);

    // single-operand commands: issue and drop
    cyc(2'b01, 8'hFF, 8'h00, 4'd4, 1'b1, 1'b0, 1'b1);
    cmp("d4_ce", ce, 1); cmp("d4_iv", inp_valid, 1); cmp("d4_opa", opa, 8'hFF);
    cyc(2'b01, 8'h11, 8'h22, 4'd6, 1'b1, 1'b0, 1'b1);
    cmp("d4_drop_ce", ce, 0); cmp("d4_drop_tmo", timeout_err, 0); cmp("d4_drop_busy", busy, 0);

    // arrival in the last wait cycle beats the timeout
    cyc(2'b01, 8'h12, 8'h00, 4'd3, 1'b1, 1'b1, 1'b1);
    idle(15);
    cyc(2'b10, 8'h00, 8'h34, 4'd0, 1'b0, 1'b0, 1'b0);
    cmp("d5_ce", ce, 1); cmp("d5_iv", inp_valid, 3); cmp("d5_tmo", timeout_err, 0);
    cmp("d5_opa", opa, 8'h12); cmp("d5_opb", opb, 8'h34); cmp("d5_cin", cin, 1);

    // reset mid-wait discards the pending command
    cyc(2'b01, 8'h5A, 8'h00, 4'd3, 1'b1, 1'b0, 1'b1);
    idle(2);
    do_reset();
    cyc(2'b10, 8'h00, 8'h77, 4'd0, 1'b0, 1'b0, 1'b0);
    cmp("d6_ce", ce, 0); cmp("d6_busy", busy, 0); cmp("d6_opa", opa, 0);
    cmp("d6_opb", opb, 0); cmp("d6_iv", inp_valid, 0);
    idle(TMO + 4);
    cmp("d6_no_tmo", timeout_err, 0);

    // randomised traffic with quiet phases to reach timeouts
    quiet = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) quiet = ~quiet;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        cyc(quiet ? ((r < 8) ? 2'b00 : 2'($urandom_range(1, 3))) : 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
